// File: rtl/rvv_vd_writeback.sv
// Vector destination writeback: merges per-lane ALU results into a VLEN-bit image
// preloaded with the old vd, honouring vl and the v0 mask, then hands it to the register file.
module rvv_vd_writeback #(
    parameter int unsigned VLEN     = 128,
    parameter int unsigned NB_LANES = 1
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        start,
    input  logic [2:0]                  vsew,
    input  logic [16:0]                 vl,
    input  logic                        instr_mask,
    input  logic                        vm,
    input  logic [VLEN-1:0]             v0,
    input  logic [VLEN-1:0]             vd_old,
    input  logic [(64<<NB_LANES)-1:0]   lane_vd,
    input  logic [(17<<NB_LANES)-1:0]   lane_idx,
    input  logic [(1<<NB_LANES)-1:0]    lane_valid,
    input  logic                        alu_done,
    output logic [VLEN-1:0]             wb_data,
    output logic                        wb_valid,
    input  logic                        wb_ready,
    output logic                        busy,
    output logic                        oob_err
);

    localparam int unsigned LANES  = 1 << NB_LANES;
    localparam int unsigned IW     = $clog2(VLEN);
    localparam logic [22:0] VLEN23 = 23'(VLEN);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WRITE
    } state_t;

    state_t            state;
    logic [VLEN-1:0]   buffer;
    logic [2:0]        vsew_q;
    logic [16:0]       vl_q;
    logic              instr_mask_q;
    logic              vm_q;
    logic [VLEN-1:0]   v0_q;

    logic [VLEN-1:0]   buf_nxt;
    logic              oob_hit;
    logic [16:0]       idx_c;
    logic [63:0]       data_c;
    logic [22:0]       off_c;
    logic [63:0]       sew_mask;
    logic              in_range;
    logic              tail_ok;
    logic              mask_ok;
    logic [VLEN-1:0]   wmask;
    logic [VLEN-1:0]   wdata;

    assign wb_data = buffer;

    always_comb begin
        case (vsew_q)
            3'd0:    sew_mask = 64'h0000_0000_0000_00FF;
            3'd1:    sew_mask = 64'h0000_0000_0000_FFFF;
            3'd2:    sew_mask = 64'h0000_0000_FFFF_FFFF;
            default: sew_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    end

    // Lanes are merged in ascending order so a higher lane overrides a lower one on the same idx.
    always_comb begin
        buf_nxt  = buffer;
        oob_hit  = 1'b0;
        idx_c    = '0;
        data_c   = '0;
        off_c    = '0;
        in_range = 1'b0;
        tail_ok  = 1'b0;
        mask_ok  = 1'b0;
        wmask    = '0;
        wdata    = '0;
        for (int k = 0; k < LANES; k++) begin
            idx_c    = lane_idx[17*k +: 17];
            data_c   = lane_vd[64*k +: 64];
            off_c    = 23'(idx_c) << (4'(vsew_q) + 4'd3);
            in_range = instr_mask_q ? (23'(idx_c) < VLEN23) : (off_c < VLEN23);
            tail_ok  = idx_c < vl_q;
            mask_ok  = vm_q || v0_q[idx_c[IW-1:0]];
            if (instr_mask_q) begin
                wmask = {{(VLEN-1){1'b0}}, 1'b1} << idx_c[IW-1:0];
                wdata = {{(VLEN-1){1'b0}}, data_c[0]} << idx_c[IW-1:0];
            end else begin
                wmask = VLEN'(sew_mask) << off_c[IW-1:0];
                wdata = VLEN'(data_c & sew_mask) << off_c[IW-1:0];
            end
            if (lane_valid[k] && !in_range)
                oob_hit = 1'b1;
            if (lane_valid[k] && in_range && tail_ok && mask_ok)
                buf_nxt = (buf_nxt & ~wmask) | (wdata & wmask);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            buffer       <= '0;
            vsew_q       <= '0;
            vl_q         <= '0;
            instr_mask_q <= 1'b0;
            vm_q         <= 1'b0;
            v0_q         <= '0;
            wb_valid     <= 1'b0;
            busy         <= 1'b0;
            oob_err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        buffer       <= vd_old;
                        vsew_q       <= vsew;
                        vl_q         <= vl;
                        instr_mask_q <= instr_mask;
                        vm_q         <= vm;
                        v0_q         <= v0;
                        oob_err      <= 1'b0;
                        busy         <= 1'b1;
                        state        <= COLLECT;
                    end
                end
                COLLECT: begin
                    buffer <= buf_nxt;
                    if (oob_hit)
                        oob_err <= 1'b1;
                    if (alu_done) begin
                        wb_valid <= 1'b1;
                        state    <= WRITE;
                    end
                end
                WRITE: begin
                    if (wb_ready) begin
                        wb_valid <= 1'b0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rvv_vd_writeback.sv
// Scoreboard bench for rvv_vd_writeback: directed instructions push expected images,
// a monitor compares them whenever the writeback handshake fires.
module tb_rvv_vd_writeback;

    logic          clk = 1'b0;
    logic          resetn;
    logic          start;
    logic [2:0]    vsew;
    logic [16:0]   vl;
    logic          instr_mask;
    logic          vm;
    logic [127:0]  v0;
    logic [127:0]  vd_old;
    logic [127:0]  lane_vd;
    logic [33:0]   lane_idx;
    logic [1:0]    lane_valid;
    logic          alu_done;
    logic [127:0]  wb_data;
    logic          wb_valid;
    logic          wb_ready;
    logic          busy;
    logic          oob_err;

    typedef struct {
        logic [127:0] data;
        logic         oob;
    } exp_t;

    exp_t exp_q[$];
    int   tests  = 0;
    int   failed = 0;

    localparam logic [127:0] ONES = {128{1'b1}};

    rvv_vd_writeback #(.VLEN(128), .NB_LANES(1)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .vsew       (vsew),
        .vl         (vl),
        .instr_mask (instr_mask),
        .vm         (vm),
        .v0         (v0),
        .vd_old     (vd_old),
        .lane_vd    (lane_vd),
        .lane_idx   (lane_idx),
        .lane_valid (lane_valid),
        .alu_done   (alu_done),
        .wb_data    (wb_data),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .busy       (busy),
        .oob_err    (oob_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        tests++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic pushExpected(input logic [127:0] data, input logic oob);
        exp_t e;
        e.data = data;
        e.oob  = oob;
        exp_q.push_back(e);
    endtask

    // Monitor: the handshake completes at the next rising edge whenever valid and ready are both high here.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resetn && wb_valid && wb_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    failed++;
                    $display("[TB] FAIL unexpected_wb: got %h expected no writeback", wb_data);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("wb_data", wb_data, e.data);
                    checkOutput("wb_oob", 128'(oob_err), 128'(e.oob));
                end
            end
        end
    end

    task automatic startInstr(input logic [2:0] s, input logic [16:0] l, input logic im,
                              input logic m, input logic [127:0] mask, input logic [127:0] old);
        vsew = s; vl = l; instr_mask = im; vm = m; v0 = mask; vd_old = old;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        vd_old = 128'h0BAD_0BAD_0BAD_0BAD_0BAD_0BAD_0BAD_0BAD;
        checkOutput("busy_after_start", 128'(busy), 128'd1);
    endtask

    task automatic applyStimulus(input logic v0k, input logic [16:0] i0, input logic [63:0] d0,
                                 input logic v1k, input logic [16:0] i1, input logic [63:0] d1,
                                 input logic done);
        lane_valid = {v1k, v0k};
        lane_idx   = {i1, i0};
        lane_vd    = {d1, d0};
        alu_done   = done;
        @(posedge clk); #1;
        lane_valid = '0;
        lane_idx   = '0;
        lane_vd    = '0;
        alu_done   = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        while (busy && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput(name, 128'(busy), 128'd0);
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; vsew = '0; vl = '0; instr_mask = 1'b0; vm = 1'b1;
        v0 = '0; vd_old = '0; lane_vd = '0; lane_idx = '0; lane_valid = '0; alu_done = 1'b0;
        wb_ready = 1'b1;
        #1;
        checkOutput("reset_wb_data", wb_data, 128'd0);
        checkOutput("reset_flags", {125'd0, wb_valid, busy, oob_err}, 128'd0);
        @(posedge clk); @(posedge clk); #1;
        resetn = 1'b1;

        // Byte elements with two lanes, vl covers all 16 bytes
        pushExpected(128'h100F0E0D0C0B0A090807060504030201, 1'b0);
        startInstr(3'd0, 17'd16, 1'b0, 1'b1, '0, '0);
        for (int c = 0; c < 8; c++) begin
            if (c == 7)
                checkOutput("valid_before_done", 128'(wb_valid), 128'd0);
            applyStimulus(1'b1, 17'(2*c), 64'(2*c+1), 1'b1, 17'(2*c+1), 64'(2*c+2), c == 7);
        end
        checkOutput("valid_after_done", 128'(wb_valid), 128'd1);
        @(posedge clk); #1;
        checkOutput("idle_after_hs", {126'd0, wb_valid, busy}, 128'd0);

        // Tail undisturbed
        pushExpected(128'hFFFFFFFFFFFFFFFF1111111111111111, 1'b0);
        startInstr(3'd2, 17'd2, 1'b0, 1'b1, '0, ONES);
        applyStimulus(1'b1, 17'd0, 64'h11111111, 1'b1, 17'd1, 64'h11111111, 1'b0);
        applyStimulus(1'b1, 17'd2, 64'h11111111, 1'b1, 17'd3, 64'h11111111, 1'b1);
        waitIdle("idle_tail");

        // Mask undisturbed
        pushExpected(128'h00000000AAAAAAAA00000000AAAAAAAA, 1'b0);
        startInstr(3'd2, 17'd4, 1'b0, 1'b0, 128'h5, '0);
        applyStimulus(1'b1, 17'd0, 64'hAAAAAAAA, 1'b1, 17'd1, 64'hAAAAAAAA, 1'b0);
        applyStimulus(1'b1, 17'd2, 64'hAAAAAAAA, 1'b1, 17'd3, 64'hAAAAAAAA, 1'b1);
        waitIdle("idle_v0");

        // Mask-producing instruction writes single bits
        pushExpected({112'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 16'h5555}, 1'b0);
        startInstr(3'd0, 17'd16, 1'b1, 1'b1, '0, ONES);
        for (int c = 0; c < 8; c++)
            applyStimulus(1'b1, 17'(2*c), 64'h1, 1'b1, 17'(2*c+1), 64'h0, c == 7);
        waitIdle("idle_maskmode");

        // Collision: lane1 wins
        pushExpected(128'h22000000, 1'b0);
        startInstr(3'd0, 17'd16, 1'b0, 1'b1, '0, '0);
        applyStimulus(1'b1, 17'd3, 64'h11, 1'b1, 17'd3, 64'h22, 1'b1);
        waitIdle("idle_collision");

        // Out-of-range byte index: no write, sticky error
        pushExpected(128'h7700, 1'b1);
        startInstr(3'd0, 17'd16, 1'b0, 1'b1, '0, '0);
        applyStimulus(1'b1, 17'd20, 64'h55, 1'b1, 17'd1, 64'h77, 1'b1);
        waitIdle("idle_oob");
        checkOutput("oob_sticky", 128'(oob_err), 128'd1);

        // 64-bit elements: idx 2 is beyond VLEN/SEW
        pushExpected(128'h0123456789ABCDEF_0000000000000000, 1'b1);
        startInstr(3'd3, 17'd4, 1'b0, 1'b1, '0, '0);
        checkOutput("oob_cleared_on_start", 128'(oob_err), 128'd0);
        applyStimulus(1'b1, 17'd2, 64'hFFFF, 1'b1, 17'd1, 64'h0123456789ABCDEF, 1'b1);
        waitIdle("idle_sew64");

        // vl=0 leaves vd_old untouched
        pushExpected(128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 1'b0);
        startInstr(3'd0, 17'd0, 1'b0, 1'b1, '0, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF);
        applyStimulus(1'b1, 17'd0, 64'hFF, 1'b1, 17'd1, 64'hFF, 1'b1);
        waitIdle("idle_vl0");

        // Backpressure; start pulses during COLLECT, WRITE and the handshake cycle are ignored
        pushExpected(128'h0000CD00000000AB, 1'b0);
        startInstr(3'd0, 17'd16, 1'b0, 1'b1, '0, '0);
        vd_old = ONES;
        start = 1'b1;
        applyStimulus(1'b0, 17'd0, 64'h0, 1'b0, 17'd0, 64'h0, 1'b0);
        start = 1'b0;
        wb_ready = 1'b0;
        applyStimulus(1'b1, 17'd0, 64'hAB, 1'b1, 17'd5, 64'hCD, 1'b1);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_valid", 128'(wb_valid), 128'd1);
            checkOutput("bp_data", wb_data, 128'h0000CD00000000AB);
            start = (i == 1);
            @(posedge clk); #1;
            start = 1'b0;
        end
        wb_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("bp_start_ignored", {126'd0, wb_valid, busy}, 128'd0);

        // Reset mid-COLLECT
        startInstr(3'd0, 17'd16, 1'b0, 1'b1, '0, ONES);
        applyStimulus(1'b1, 17'd20, 64'h0, 1'b1, 17'd0, 64'h5A, 1'b0);
        #2 resetn = 1'b0;
        #1;
        checkOutput("rst_wb_data", wb_data, 128'd0);
        checkOutput("rst_flags", {125'd0, wb_valid, busy, oob_err}, 128'd0);
        #2 resetn = 1'b1;
        @(posedge clk); #1;
        pushExpected(128'h1277, 1'b0);
        startInstr(3'd0, 17'd16, 1'b0, 1'b1, '0, 128'h1234);
        applyStimulus(1'b1, 17'd0, 64'h77, 1'b0, 17'd0, 64'h0, 1'b1);
        waitIdle("idle_after_reset");

        repeat (3) @(posedge clk);
        #1;
        checkOutput("queue_empty", 128'(exp_q.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/rvv_vd_writeback.md
# rvv_vd_writeback

Downstream stage of the multi-lane vector ALU wrapper. Collects the per-lane element results (data, element index, lane-valid) the ALU lanes emit each cycle and merges them into a VLEN-bit destination image. The image is preloaded with the old destination register and honours vl (tail undisturbed) and the v0 mask (mask undisturbed). When the ALU signals done, the block presents the assembled register to the register-file write port through a valid/ready handshake.

## Interface
- VLEN, 17'd128, vector register width in bits.
- NB_LANES, 1, log2 of lane count; lanes = 1<<NB_LANES (1..8).
- clk  in  1  clock; everything samples on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins an instruction; accepted only in IDLE.
- vsew  in  3  SEW = 8<<vsew (0..3 legal); latched on start.
- vl  in  17  active element count; latched on start.
- instr_mask  in  1  1 = mask-producing instruction (compare); latched on start.
- vm  in  1  1 = unmasked; latched on start.
- v0  in  VLEN  mask register; latched on start.
- vd_old  in  VLEN  current destination contents; loaded into the buffer on start.
- lane_vd  in  64<<NB_LANES  per-lane result; lane k occupies bits [64k+63:64k].
- lane_idx  in  17<<NB_LANES  per-lane element index; lane k occupies bits [17k+16:17k].
- lane_valid  in  1<<NB_LANES  per-lane result valid.
- alu_done  in  1  ALU finished; lanes valid in this same cycle are still captured.
- wb_data  out  VLEN  assembled destination; reset 0.
- wb_valid  out  1  wb_data is final; reset 0.
- wb_ready  in  1  register file accepts.
- busy  out  1  high outside IDLE; reset 0.
- oob_err  out  1  sticky; set on any out-of-range index; cleared on the next accepted start; reset 0.

## Operation
- FSM has three states: IDLE, COLLECT, WRITE.
- IDLE: on start, buffer <= vd_old, latch the control inputs, clear oob_err, go to COLLECT.
- COLLECT: each cycle, for every k with lane_valid[k] set, take idx = lane_idx slice k.
  - Element mode (instr_mask=0): write SEW bits lane_vd[64k+SEW-1:64k] to buffer bits [idx*SEW +: SEW].
  - Mask mode (instr_mask=1): write lane_vd[64k] to buffer bit idx.
  - A write is suppressed if idx >= vl (tail undisturbed).
  - A write is suppressed if vm=0 and v0[idx]=0 (mask undisturbed).
  - Element mode: idx >= VLEN/SEW means no write and oob_err <= 1.
  - Mask mode: idx >= VLEN means no write and oob_err <= 1.
  - Two lanes with the same idx in one cycle: the higher lane number wins.
  - alu_done=1: perform this cycle's writes, then go to WRITE.
- WRITE: wb_valid=1, wb_data = buffer. lane_valid, alu_done and start are ignored. When wb_valid && wb_ready, go to IDLE.
- wb_data is driven from the buffer in all states; it is only meaningful while wb_valid is high.
- Index arithmetic: idx*SEW is computed as idx<<(vsew+3) at 17+6 bits, so there is no truncation before the range check.

## Timing
- start sampled at edge T: buffer and latches update at T; busy=1 from T.
- Lane writes sampled at an edge appear in wb_data after that edge, i.e. one cycle latency.
- alu_done sampled at edge D: wb_valid=1 from D; minimum latency is one cycle after alu_done.
- Handshake completes at the first edge where wb_valid && wb_ready. wb_valid and busy are 0 after that edge.
- wb_data and wb_valid are held stable while wb_ready=0, for any number of cycles.
- start asserted while busy has no effect and is not queued.
- start arriving in the same cycle as handshake completion is ignored; a new start is legal from the following cycle.
- resetn low, at any time including mid-COLLECT or mid-WRITE: immediately IDLE, buffer=0, wb_data=0, wb_valid=0, busy=0, oob_err=0.
- vl=0: no element is written; WRITE returns vd_old unchanged.

## Test plan
- VLEN=128, NB_LANES=1, vsew=0, vl=16, vm=1, vd_old=0. Lanes deliver idx 2c and 2c+1 in cycle c with data idx+1; alu_done with the last pair. -> wb_data=0x100F0E0D0C0B0A090807060504030201, wb_valid exactly one cycle after alu_done.
- vsew=2, vl=2, vd_old=all-ones. Write idx 0..3 with data 0x11111111. -> wb_data=0xFFFFFFFFFFFFFFFF1111111111111111 (tail kept).
- vsew=2, vl=4, vm=0, v0=0x5, vd_old=0. Write idx 0..3 with data 0xAAAAAAAA. -> wb_data=0x00000000AAAAAAAA00000000AAAAAAAA.
- instr_mask=1, vl=16, vd_old=all-ones. Write bits idx 0..15 with values 1,0,1,0,... -> wb_data[15:0]=0x5555, wb_data[127:16] all ones.
- Out-of-range index and collision:
  - lane0 and lane1 both write idx 3 in one cycle (lane0 data 0x11, lane1 data 0x22, vsew=0) -> byte 3 = 0x22.
  - idx 20 with vsew=0 -> no write, oob_err=1 until the next start.
- Backpressure and reset:
  - wb_ready low for 5 cycles after wb_valid -> data stable, start pulses ignored; handshake completes on the 6th cycle.
  - resetn pulsed low mid-COLLECT -> all outputs 0 immediately; the next start behaves normally.
